mac_divider: RTL and testbench
==============================

# mac_divider

Sequential restoring divider: the inverse of the team's A*B+C multiply-accumulate register. Takes a result word Y and a divisor B, and recovers quotient Q and remainder Rm such that Y = Q*B + Rm with Rm < B. It is the consumer end of the MAC datapath: it checks and decomposes MAC outputs, one quotient bit per clock. Valid/ready handshakes are used on both the input and output sides.

## Interface
Parameters:
- R, 8: operand width; the divisor and remainder are R bits wide.
- outR, 16: result-word width; the dividend and quotient are outR bits wide. Constraint: outR >= R.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-low.
- in_valid, input, 1: DATA_IN and DIV are valid.
- in_ready, output, 1: the block can accept an operation.
- DATA_IN, input, outR: dividend Y, unsigned.
- DIV, input, R: divisor B, unsigned.
- out_valid, output, 1: the result outputs are valid.
- out_ready, input, 1: downstream accepts the result.
- QUOT, output, outR: quotient Q.
- REM, output, R: remainder Rm.
- div_zero, output, 1: the completed operation had DIV == 0.

## Operation
- FSM states:
  - IDLE: in_ready = 1; all other handshake outputs low.
  - RUN: outR iteration cycles.
  - DONE: out_valid = 1; outputs held.
- in_ready is combinational and equals (state == IDLE).
- IDLE -> RUN on in_valid && in_ready with DIV != 0. At that edge:
  - capture DATA_IN into the dividend shift register and DIV into the divisor register;
  - clear the partial remainder P (R+1 bits);
  - load the step counter with outR.
- IDLE -> DONE on acceptance with DIV == 0:
  - QUOT = all ones, REM = DATA_IN[R-1:0], div_zero = 1;
  - no RUN cycles are spent.
- RUN step, once per cycle:
  - P' = {P[R-1:0], dividend MSB};
  - shift the dividend left by 1;
  - if P' >= divisor: P = P' - divisor and the shifted-in quotient LSB = 1; otherwise P = P' and the LSB = 0;
  - decrement the counter.
- The comparison is R+1 bits wide, so there is no overflow; P < divisor holds after every step.
- RUN -> DONE on the step where the counter equals 1. At that edge:
  - QUOT gets the final quotient register;
  - REM gets the final P[R-1:0];
  - div_zero = 0.
- DONE -> IDLE on out_ready. Outputs keep their values until the next operation's DONE; only out_valid drops.
- While in RUN or DONE, in_valid is ignored and DATA_IN/DIV changes have no effect. Operands are captured only at acceptance.
- There is no back-to-back overlap. After an output handshake, the block spends at least one cycle in IDLE before the next acceptance.

## Timing
- Reset (rst = 0 at a rising edge):
  - state = IDLE, out_valid = 0, QUOT = 0, REM = 0, div_zero = 0, counter = 0;
  - in_ready = 1 from the cycle after the reset edge;
  - rst dominates every other input.
- Reset mid-RUN or in DONE aborts the operation and discards the result. The outputs clear at that edge.
- Latency with DIV != 0: acceptance at edge t; steps at edges t+1 .. t+outR; out_valid high in the cycle following edge t+outR. That is outR cycles after acceptance (16 for the defaults).
- Latency with DIV == 0: out_valid high in the cycle following the acceptance edge.
- Throughput is one operation per outR + 2 cycles when out_ready is held high.
- out_valid, QUOT, REM and div_zero are registered. in_ready is combinational from state only and does not depend on any input.
- Backpressure: DONE is held indefinitely while out_ready = 0. QUOT, REM and div_zero stay stable during that time.
- out_ready asserted in any state other than DONE has no effect.

## Test plan
- Basic division: DATA_IN = 1000, DIV = 7, out_ready = 1 -> QUOT = 142, REM = 6, div_zero = 0. out_valid rises exactly 16 cycles after the acceptance edge; in_ready is low throughout RUN and DONE.
- MAC round trip: A = 255, B = 255, C = 254, so DATA_IN = 65279 and DIV = 255 -> QUOT = 255, REM = 254. Then DATA_IN = 65535, DIV = 1 -> QUOT = 65535, REM = 0.
- Divide by zero: DATA_IN = 0x1234, DIV = 0 -> QUOT = 0xFFFF, REM = 0x34, div_zero = 1. out_valid is high in the cycle after acceptance.
- Backpressure: DATA_IN = 500, DIV = 9 with out_ready held low for 5 cycles after out_valid.
  - Required: QUOT = 55 and REM = 5 stay stable; in_ready = 0; a new in_valid with different operands is ignored.
  - Then raise out_ready: the next cycle shows out_valid = 0 and in_ready = 1.
- Reset mid-operation: DATA_IN = 40000, DIV = 3, then drive rst low at the 8th RUN edge.
  - Required: after that edge, out_valid = 0, QUOT = 0, REM = 0, in_ready = 1.
  - A following operation with DATA_IN = 40000, DIV = 3 gives QUOT = 13333, REM = 1.
- Edge values:
  - DATA_IN = 0, DIV = 200 -> QUOT = 0, REM = 0.
  - DATA_IN = 199, DIV = 200 -> QUOT = 0, REM = 199.
  - DATA_IN = 200, DIV = 200 -> QUOT = 1, REM = 0.

Source files
------------

// File: rtl/mac_divider.sv
// Sequential restoring divider: splits a MAC result word Y by divisor B into
// quotient and remainder, one quotient bit per clock, valid/ready on both sides.
module mac_divider #(
   parameter int R    = 8,
   parameter int outR = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [outR-1:0] DATA_IN,
   input  logic [R-1:0]    DIV,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [outR-1:0] QUOT,
   output logic [R-1:0]    REM,
   output logic            div_zero
);

   localparam int CW = $clog2(outR + 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(outR);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   logic [outR-1:0] dvd_r;     // dividend shifts out the top, quotient fills the bottom
   logic [R-1:0]    dvs_r;
   logic [R-1:0]    p_r;       // partial remainder; always < divisor between steps
   logic [CW-1:0]   cnt_r;

   logic [R:0]      p_shift_s;
   logic            ge_s;
   logic [R-1:0]    p_next_s;
   logic [outR-1:0] dvd_next_s;

   assign in_ready = (state_r == IDLE);

   // One restoring step: shift in the next dividend bit, subtract when it fits.
   always_comb begin
      p_shift_s  = {p_r, dvd_r[outR-1]};
      ge_s       = (p_shift_s >= {1'b0, dvs_r});
      p_next_s   = p_shift_s[R-1:0];
      dvd_next_s = (dvd_r << 1) | {{(outR-1){1'b0}}, ge_s};
      if (ge_s) begin
         // Difference is below the divisor, so its top bit is always zero.
         p_next_s = p_shift_s[R-1:0] - dvs_r;
      end else begin
         p_next_s = p_shift_s[R-1:0];
      end
   end

   // Control FSM, datapath registers and registered result outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= IDLE;
         dvd_r     <= {outR{1'b0}};
         dvs_r     <= {R{1'b0}};
         p_r       <= {R{1'b0}};
         cnt_r     <= CNT_ZERO;
         out_valid <= 1'b0;
         QUOT      <= {outR{1'b0}};
         REM       <= {R{1'b0}};
         div_zero  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  if (DIV != {R{1'b0}}) begin
                     dvd_r   <= DATA_IN;
                     dvs_r   <= DIV;
                     p_r     <= {R{1'b0}};
                     cnt_r   <= CNT_LOAD;
                     state_r <= RUN;
                  end else begin
                     QUOT      <= {outR{1'b1}};
                     REM       <= DATA_IN[R-1:0];
                     div_zero  <= 1'b1;
                     out_valid <= 1'b1;
                     state_r   <= DONE;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               p_r   <= p_next_s;
               dvd_r <= dvd_next_s;
               cnt_r <= cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  QUOT      <= dvd_next_s;
                  REM       <= p_next_s;
                  div_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_divider.sv
// Self-checking bench for mac_divider: directed cases from the test plan plus
// random operands checked against plain integer division.
module tb_mac_divider;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] DATA_IN;
   logic [7:0]  DIV;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] QUOT;
   logic [7:0]  REM;
   logic        div_zero;

   int checks   = 0;
   int failures = 0;

   mac_divider #(.R(8), .outR(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .DATA_IN   (DATA_IN),
      .DIV       (DIV),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .QUOT      (QUOT),
      .REM       (REM),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation, wait for out_valid, check latency, busy flag and results.
   task automatic run_op(input logic [15:0] y, input logic [7:0] b, input string tag);
      int  edges;
      bit  busy_bad;
      int  exp_q;
      int  exp_r;
      if (b == 8'd0) begin
         exp_q = 32'hFFFF;
         exp_r = int'(y) % 256;
      end else begin
         exp_q = int'(y) / int'(b);
         exp_r = int'(y) % int'(b);
      end
      DATA_IN  = y;
      DIV      = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      DATA_IN  = 16'($urandom);
      DIV      = 8'($urandom);
      edges    = 0;
      busy_bad = 1'b0;
      while (!out_valid && edges < 40) begin
         if (in_ready !== 1'b0) busy_bad = 1'b1;
         step();
         edges++;
      end
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      check({tag, "_latency"}, edges, (b == 8'd0) ? 32'd0 : 32'd16);
      check({tag, "_busy"}, busy_bad, 32'd0);
      check({tag, "_quot"}, QUOT, exp_q);
      check({tag, "_rem"}, REM, exp_r);
      check({tag, "_dz"}, div_zero, (b == 8'd0) ? 32'd1 : 32'd0);
   endtask

   // With out_ready high the result is consumed on the next edge.
   task automatic drain(input string tag);
      step();
      check({tag, "_drain_ov"}, out_valid, 32'd0);
      check({tag, "_drain_rdy"}, in_ready, 32'd1);
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      DATA_IN   = 16'd0;
      DIV       = 8'd0;
      step();
      step();
      check("rst_out_valid", out_valid, 32'd0);
      check("rst_quot", QUOT, 32'd0);
      check("rst_rem", REM, 32'd0);
      check("rst_dz", div_zero, 32'd0);
      check("rst_in_ready", in_ready, 32'd1);
      rst = 1'b1;

      run_op(16'd1000, 8'd7, "basic");
      drain("basic");
      run_op(16'd65279, 8'd255, "mac_rt");
      drain("mac_rt");
      run_op(16'd65535, 8'd1, "div_one");
      drain("div_one");
      run_op(16'h1234, 8'd0, "div_zero");
      drain("div_zero");

      // Backpressure: hold out_ready low and offer a competing operation.
      out_ready = 1'b0;
      run_op(16'd500, 8'd9, "bp");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         DATA_IN  = 16'd777;
         DIV      = 8'd5;
         step();
         check("bp_hold_ov", out_valid, 32'd1);
         check("bp_hold_quot", QUOT, 32'd55);
         check("bp_hold_rem", REM, 32'd5);
         check("bp_hold_rdy", in_ready, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain("bp");

      // Reset at the 8th RUN edge discards the operation.
      DATA_IN  = 16'd40000;
      DIV      = 8'd3;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check("mid_run_busy", out_valid, 32'd0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("abort_ov", out_valid, 32'd0);
      check("abort_quot", QUOT, 32'd0);
      check("abort_rem", REM, 32'd0);
      check("abort_rdy", in_ready, 32'd1);
      run_op(16'd40000, 8'd3, "after_abort");
      drain("after_abort");

      run_op(16'd0, 8'd200, "edge0");
      drain("edge0");
      run_op(16'd199, 8'd200, "edge199");
      drain("edge199");
      run_op(16'd200, 8'd200, "edge200");
      drain("edge200");

      for (int i = 0; i < 25; i++) begin
         logic [15:0] ry;
         logic [7:0]  rb;
         ry = 16'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         run_op(ry, rb, "rand");
         drain("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
